pb_mailbox: RTL and testbench

Parametrised bidirectional mailbox joining two PicoBlaze (kcpsm3) port buses, side A and side B. Each direction has its own DEPTH-entry FIFO, so producer and consumer no longer lock-step through single holding registers and interrupt flops. Each side has an optional per-side XOR key (Vernam mode) applied on push and on pop, and raises an interrupt to its core when data arrives. It replaces the hand-wired output-DFF/interrupt-DFF/mux glue between two cores.

---
 rtl/pb_mailbox.sv | 213 +++++++++++++++++++++
 tb/tb_pb_mailbox.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_mailbox.sv
// Bidirectional PicoBlaze (kcpsm3) mailbox: one FIFO per direction, per-side XOR key,
// sticky overflow/underflow flags and a data-arrival interrupt toward each core.

module pb_mailbox_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_c,
    output logic             o_empty_c,
    output logic             o_full_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty; wraps modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + PW'(1);
            if (i_pop)  r_rp <= r_rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
    end

    assign o_head_c  = r_mem[r_rp[AW-1:0]];
    assign o_empty_c = (r_wp == r_rp);
    assign o_full_c  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
endmodule

// One core's register view: DATA/STATUS/KEY/CTRL decode, cipher, sticky flags, interrupt.
module pb_mailbox_port #(
    parameter int unsigned WIDTH = 8,
    parameter logic [7:0]  BASE  = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       i_port_id,
    input  logic [WIDTH-1:0] i_out_port,
    input  logic             i_write_strobe,
    input  logic             i_read_strobe,
    input  logic             i_interrupt_ack,
    output logic [WIDTH-1:0] o_in_port,
    output logic             o_interrupt,
    input  logic [WIDTH-1:0] i_rx_head,
    input  logic             i_rx_empty,
    input  logic             i_rx_full,
    input  logic             i_tx_empty,
    input  logic             i_tx_full,
    input  logic             i_rx_push,
    output logic             o_push_c,
    output logic [WIDTH-1:0] o_push_data_c,
    output logic             o_pop_c
);
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_KEY    = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    logic             w_sel;
    logic [1:0]       w_off;
    logic             w_wr;
    logic             w_rd;
    logic             w_wr_data;
    logic             w_rd_data;
    logic [WIDTH-1:0] w_mask;
    logic [6:0]       w_status;
    logic [WIDTH-1:0] w_rdata;

    logic [WIDTH-1:0] r_key;
    logic             r_cipher;
    logic             r_irq_en;
    logic             r_ovf;
    logic             r_udf;
    logic             r_irq;
    logic [WIDTH-1:0] r_in_port;

    assign w_sel     = (i_port_id[7:2] == BASE[7:2]);
    assign w_off     = i_port_id[1:0];
    assign w_wr      = i_write_strobe && w_sel;
    assign w_rd      = i_read_strobe && w_sel;
    assign w_wr_data = w_wr && (w_off == OFF_DATA);
    assign w_rd_data = w_rd && (w_off == OFF_DATA);
    assign w_mask    = r_cipher ? r_key : '0;
    assign w_status  = {r_irq, r_udf, r_ovf, i_tx_full, i_tx_empty, i_rx_full, i_rx_empty};

    // Full/empty are judged on pre-edge state, so a blocked access never moves a pointer.
    assign o_push_c      = w_wr_data && !i_tx_full;
    assign o_push_data_c = i_out_port ^ w_mask;
    assign o_pop_c       = w_rd_data && !i_rx_empty;

    always_comb begin
        w_rdata = '0;
        if (w_sel) begin
            case (w_off)
                OFF_DATA:   if (!i_rx_empty) w_rdata = i_rx_head ^ w_mask;
                OFF_STATUS: w_rdata = WIDTH'(w_status);
                OFF_KEY:    w_rdata = r_key;
                default:    w_rdata = WIDTH'({r_irq_en, r_cipher});
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key     <= '0;
            r_cipher  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_irq     <= 1'b0;
            r_in_port <= '0;
        end else begin
            r_in_port <= w_rdata;
            if (w_wr && (w_off == OFF_KEY)) r_key <= i_out_port;
            if (w_wr && (w_off == OFF_CTRL)) begin
                r_cipher <= i_out_port[0];
                r_irq_en <= i_out_port[1];
            end
            if (w_wr_data && i_tx_full)
                r_ovf <= 1'b1;
            else if (w_wr && (w_off == OFF_STATUS) && i_out_port[4])
                r_ovf <= 1'b0;
            if (w_rd_data && i_rx_empty)
                r_udf <= 1'b1;
            else if (w_wr && (w_off == OFF_STATUS) && i_out_port[5])
                r_udf <= 1'b0;
            // A new arrival outranks a same-cycle acknowledge.
            if (i_rx_push && r_irq_en)
                r_irq <= 1'b1;
            else if (i_interrupt_ack)
                r_irq <= 1'b0;
        end
    end

    assign o_in_port   = r_in_port;
    assign o_interrupt = r_irq;
endmodule

// Top: FIFO AB carries A->B, FIFO BA carries B->A.
module pb_mailbox #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter logic [7:0]  BASE  = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       a_port_id,
    input  logic [WIDTH-1:0] a_out_port,
    input  logic             a_write_strobe,
    input  logic             a_read_strobe,
    output logic [WIDTH-1:0] a_in_port,
    output logic             a_interrupt,
    input  logic             a_interrupt_ack,
    input  logic [7:0]       b_port_id,
    input  logic [WIDTH-1:0] b_out_port,
    input  logic             b_write_strobe,
    input  logic             b_read_strobe,
    output logic [WIDTH-1:0] b_in_port,
    output logic             b_interrupt,
    input  logic             b_interrupt_ack
);
    logic             w_ab_push, w_ab_pop, w_ab_empty, w_ab_full;
    logic             w_ba_push, w_ba_pop, w_ba_empty, w_ba_full;
    logic [WIDTH-1:0] w_ab_wdata, w_ab_head, w_ba_wdata, w_ba_head;

    pb_mailbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_ab (
        .clk(clk), .rst_n(reset),
        .i_push(w_ab_push), .i_wdata(w_ab_wdata), .i_pop(w_ab_pop),
        .o_head_c(w_ab_head), .o_empty_c(w_ab_empty), .o_full_c(w_ab_full)
    );

    pb_mailbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_ba (
        .clk(clk), .rst_n(reset),
        .i_push(w_ba_push), .i_wdata(w_ba_wdata), .i_pop(w_ba_pop),
        .o_head_c(w_ba_head), .o_empty_c(w_ba_empty), .o_full_c(w_ba_full)
    );

    pb_mailbox_port #(.WIDTH(WIDTH), .BASE(BASE)) u_port_a (
        .clk(clk), .rst_n(reset),
        .i_port_id(a_port_id), .i_out_port(a_out_port),
        .i_write_strobe(a_write_strobe), .i_read_strobe(a_read_strobe),
        .i_interrupt_ack(a_interrupt_ack),
        .o_in_port(a_in_port), .o_interrupt(a_interrupt),
        .i_rx_head(w_ba_head), .i_rx_empty(w_ba_empty), .i_rx_full(w_ba_full),
        .i_tx_empty(w_ab_empty), .i_tx_full(w_ab_full), .i_rx_push(w_ba_push),
        .o_push_c(w_ab_push), .o_push_data_c(w_ab_wdata), .o_pop_c(w_ba_pop)
    );

    pb_mailbox_port #(.WIDTH(WIDTH), .BASE(BASE)) u_port_b (
        .clk(clk), .rst_n(reset),
        .i_port_id(b_port_id), .i_out_port(b_out_port),
        .i_write_strobe(b_write_strobe), .i_read_strobe(b_read_strobe),
        .i_interrupt_ack(b_interrupt_ack),
        .o_in_port(b_in_port), .o_interrupt(b_interrupt),
        .i_rx_head(w_ab_head), .i_rx_empty(w_ab_empty), .i_rx_full(w_ab_full),
        .i_tx_empty(w_ba_empty), .i_tx_full(w_ba_full), .i_rx_push(w_ab_push),
        .o_push_c(w_ba_push), .o_push_data_c(w_ba_wdata), .o_pop_c(w_ab_pop)
    );
endmodule

// File: tb/tb_pb_mailbox.sv
// Scoreboard bench for pb_mailbox: queue-per-direction model plus per-side register model.

module tb_pb_mailbox;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  BASE  = 8'h00;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] a_port_id, b_port_id;
    logic [WIDTH-1:0] a_out_port, b_out_port, a_in_port, b_in_port;
    logic a_write_strobe, a_read_strobe, a_interrupt, a_interrupt_ack;
    logic b_write_strobe, b_read_strobe, b_interrupt, b_interrupt_ack;

    always #5 clk = ~clk;

    pb_mailbox #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .reset(reset),
        .a_port_id(a_port_id), .a_out_port(a_out_port),
        .a_write_strobe(a_write_strobe), .a_read_strobe(a_read_strobe),
        .a_in_port(a_in_port), .a_interrupt(a_interrupt), .a_interrupt_ack(a_interrupt_ack),
        .b_port_id(b_port_id), .b_out_port(b_out_port),
        .b_write_strobe(b_write_strobe), .b_read_strobe(b_read_strobe),
        .b_in_port(b_in_port), .b_interrupt(b_interrupt), .b_interrupt_ack(b_interrupt_ack)
    );

    // Scoreboard: stored (post-push-cipher) words per direction.
    logic [7:0] q_ab[$];
    logic [7:0] q_ba[$];
    logic [7:0] m_key [2];
    logic       m_cipher [2];
    logic       m_irq_en [2];
    logic       m_ovf [2];
    logic       m_udf [2];
    logic       m_irq [2];
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pid(input logic [1:0] off);
        return {BASE[7:2], off};
    endfunction

    function automatic logic [7:0] mask(input int s);
        return m_cipher[s] ? m_key[s] : 8'h00;
    endfunction

    function automatic logic [7:0] m_status(input int s);
        int tx, rx;
        tx = (s == 0) ? q_ab.size() : q_ba.size();
        rx = (s == 0) ? q_ba.size() : q_ab.size();
        return {1'b0, m_irq[s], m_udf[s], m_ovf[s],
                tx == int'(DEPTH), tx == 0, rx == int'(DEPTH), rx == 0};
    endfunction

    task automatic m_reset();
        q_ab.delete();
        q_ba.delete();
        for (int s = 0; s < 2; s++) begin
            m_key[s] = 8'h00; m_cipher[s] = 1'b0; m_irq_en[s] = 1'b0;
            m_ovf[s] = 1'b0;  m_udf[s] = 1'b0;    m_irq[s] = 1'b0;
        end
    endtask

    task automatic m_push(input int s, input logic [7:0] d);
        if (s == 0) begin
            if (q_ab.size() >= int'(DEPTH)) m_ovf[0] = 1'b1;
            else begin
                q_ab.push_back(d ^ mask(0));
                if (m_irq_en[1]) m_irq[1] = 1'b1;
            end
        end else begin
            if (q_ba.size() >= int'(DEPTH)) m_ovf[1] = 1'b1;
            else begin
                q_ba.push_back(d ^ mask(1));
                if (m_irq_en[0]) m_irq[0] = 1'b1;
            end
        end
    endtask

    task automatic m_pop(input int s, output logic [7:0] exp);
        exp = 8'h00;
        if (s == 0) begin
            if (q_ba.size() == 0) m_udf[0] = 1'b1;
            else exp = q_ba.pop_front() ^ mask(0);
        end else begin
            if (q_ab.size() == 0) m_udf[1] = 1'b1;
            else exp = q_ab.pop_front() ^ mask(1);
        end
    endtask

    task automatic drv(input int s, input logic [7:0] p, input logic [7:0] d,
                       input logic wr, input logic rd);
        if (s == 0) begin
            a_port_id = p; a_out_port = d; a_write_strobe = wr; a_read_strobe = rd;
        end else begin
            b_port_id = p; b_out_port = d; b_write_strobe = wr; b_read_strobe = rd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        a_write_strobe = 1'b0; a_read_strobe = 1'b0; a_interrupt_ack = 1'b0;
        b_write_strobe = 1'b0; b_read_strobe = 1'b0; b_interrupt_ack = 1'b0;
    endtask

    task automatic check_irq(input string tag);
        check({tag, "_a_irq"}, a_interrupt, m_irq[0]);
        check({tag, "_b_irq"}, b_interrupt, m_irq[1]);
    endtask

    task automatic wr_reg(input int s, input logic [1:0] off, input logic [7:0] d);
        drv(s, pid(off), d, 1'b1, 1'b0);
        case (off)
            2'd0: m_push(s, d);
            2'd1: begin
                if (d[4]) m_ovf[s] = 1'b0;
                if (d[5]) m_udf[s] = 1'b0;
            end
            2'd2: m_key[s] = d;
            default: begin
                m_cipher[s] = d[0];
                m_irq_en[s] = d[1];
            end
        endcase
        tick();
        check_irq("wr");
    endtask

    task automatic rd_data(input int s, input string tag);
        logic [7:0] exp;
        drv(s, pid(2'd0), 8'h00, 1'b0, 1'b1);
        m_pop(s, exp);
        tick();
        check(tag, (s == 0) ? a_in_port : b_in_port, exp);
    endtask

    task automatic rd_reg(input int s, input logic [1:0] off, input string tag);
        logic [7:0] exp;
        drv(s, pid(off), 8'h00, 1'b0, 1'b1);
        if (off == 2'd1)      exp = m_status(s);
        else if (off == 2'd2) exp = m_key[s];
        else                  exp = {6'b0, m_irq_en[s], m_cipher[s]};
        tick();
        check(tag, (s == 0) ? a_in_port : b_in_port, exp);
    endtask

    task automatic ack(input int s);
        if (s == 0) a_interrupt_ack = 1'b1; else b_interrupt_ack = 1'b1;
        m_irq[s] = 1'b0;
        tick();
        check_irq("ack");
    endtask

    // A pushes FIFO AB while B pops it in the same cycle; both judged on pre-edge occupancy.
    task automatic push_pop(input logic [7:0] d, input string tag);
        logic [7:0] exp;
        drv(0, pid(2'd0), d, 1'b1, 1'b0);
        drv(1, pid(2'd0), 8'h00, 1'b0, 1'b1);
        if (q_ab.size() == 0) begin
            m_pop(1, exp);
            m_push(0, d);
        end else begin
            m_push(0, d);
            m_pop(1, exp);
        end
        tick();
        check(tag, b_in_port, exp);
        check_irq(tag);
    endtask

    initial begin
        m_reset();
        reset = 1'b0;
        a_interrupt_ack = 1'b0; b_interrupt_ack = 1'b0;
        drv(0, 8'h00, 8'h00, 1'b0, 1'b0);
        drv(1, 8'h00, 8'h00, 1'b0, 1'b0);
        #12;
        check("rst_a_in", a_in_port, 0);
        check("rst_b_in", b_in_port, 0);
        check_irq("rst");
        reset = 1'b1;
        tick();
        rd_reg(0, 2'd1, "rst_status_a");
        rd_reg(1, 2'd1, "rst_status_b");

        // Basic transfer with interrupt
        wr_reg(1, 2'd3, 8'h02);
        wr_reg(0, 2'd3, 8'h02);
        wr_reg(0, 2'd0, 8'h41);
        check("basic_b_irq_rise", b_interrupt, 1);
        rd_data(1, "basic_rd");
        check("basic_rd_const", b_in_port, 8'h41);
        ack(1);
        check("basic_ack_drop", b_interrupt, 0);
        rd_reg(1, 2'd1, "basic_status_b");

        // Vernam
        wr_reg(0, 2'd2, 8'h5A);
        wr_reg(1, 2'd2, 8'h5A);
        wr_reg(0, 2'd3, 8'h03);
        wr_reg(1, 2'd3, 8'h03);
        wr_reg(0, 2'd0, 8'h41);
        rd_data(1, "vernam_rd_plain");
        wr_reg(1, 2'd3, 8'h02);
        wr_reg(0, 2'd0, 8'h41);
        rd_data(1, "vernam_rd_raw");
        check("vernam_stored_const", b_in_port, 8'h1B);
        wr_reg(1, 2'd0, 8'hC3);
        rd_data(0, "vernam_ba_rd");
        rd_reg(0, 2'd2, "vernam_key_a");
        rd_reg(0, 2'd3, "vernam_ctrl_a");
        wr_reg(0, 2'd3, 8'h02);
        ack(0);
        ack(1);

        // Overflow / underflow
        for (int i = 0; i < 17; i++) begin
            wr_reg(0, 2'd0, 8'(i));
            if (i == 15) rd_reg(0, 2'd1, "ovf_tx_full");
        end
        rd_reg(0, 2'd1, "ovf_status_a");
        rd_reg(1, 2'd1, "ovf_status_b");
        for (int i = 0; i < 16; i++) rd_data(1, "ovf_drain");
        rd_data(1, "udf_rd_zero");
        rd_reg(1, 2'd1, "udf_status_b");
        wr_reg(0, 2'd1, 8'h30);
        wr_reg(1, 2'd1, 8'h30);
        rd_reg(0, 2'd1, "clr_status_a");
        rd_reg(1, 2'd1, "clr_status_b");
        ack(1);

        // Same-cycle push/pop at full and at empty
        for (int i = 0; i < 16; i++) wr_reg(0, 2'd0, 8'(8'h80 + i));
        push_pop(8'hEE, "pp_full");
        rd_reg(0, 2'd1, "pp_full_status_a");
        for (int i = 0; i < 15; i++) rd_data(1, "pp_full_drain");
        push_pop(8'h55, "pp_empty");
        rd_reg(1, 2'd1, "pp_empty_status_b");
        rd_data(1, "pp_empty_rd");
        wr_reg(0, 2'd1, 8'h30);
        wr_reg(1, 2'd1, 8'h30);
        ack(1);

        // Ack coincident with a new push
        wr_reg(0, 2'd0, 8'h11);
        drv(0, pid(2'd0), 8'h22, 1'b1, 1'b0);
        b_interrupt_ack = 1'b1;
        m_irq[1] = 1'b0;
        m_push(0, 8'h22);
        tick();
        check("ack_vs_push", b_interrupt, 1);
        rd_data(1, "ackpush_rd1");
        rd_data(1, "ackpush_rd2");
        ack(1);

        // Pointer wrap, both directions
        for (int i = 0; i < 40; i++) begin
            wr_reg(0, 2'd0, 8'($urandom));
            rd_reg(1, 2'd1, "wrap_status_b");
            rd_data(1, "wrap_ab");
        end
        for (int i = 0; i < 40; i++) begin
            wr_reg(1, 2'd0, 8'($urandom));
            rd_data(0, "wrap_ba");
            rd_reg(0, 2'd1, "wrap_status_a");
        end
        ack(0);
        ack(1);

        // Port ids outside the window
        wr_reg(0, 2'd2, 8'h3C);
        rd_reg(0, 2'd2, "oow_key_before");
        drv(0, 8'h06, 8'h00, 1'b0, 1'b1);
        tick();
        check("oow_rd_zero", a_in_port, 0);
        drv(0, 8'h10, 8'h77, 1'b1, 1'b0);
        tick();
        drv(0, 8'h0E, 8'hFF, 1'b1, 1'b0);
        tick();
        rd_reg(1, 2'd1, "oow_status_b");
        rd_reg(0, 2'd2, "oow_key_after");

        // Asynchronous reset with data queued and interrupt pending
        for (int i = 0; i < 5; i++) wr_reg(0, 2'd0, 8'(i + 1));
        rd_reg(0, 2'd2, "prerst_key");
        check("prerst_b_irq", b_interrupt, 1);
        reset = 1'b0;
        #2;
        m_reset();
        check("arst_a_in", a_in_port, 0);
        check("arst_b_in", b_in_port, 0);
        check_irq("arst");
        #2;
        reset = 1'b1;
        tick();
        rd_reg(0, 2'd1, "postrst_status_a");
        rd_reg(1, 2'd1, "postrst_status_b");
        rd_data(1, "postrst_rd_empty");
        rd_reg(1, 2'd1, "postrst_udf_b");
        rd_reg(0, 2'd2, "postrst_key_a");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
